mem_arbiter: RTL
================

# mem_arbiter

Shares the single processor-memory port between the instruction cache and the data cache. Each cycle it grants at most one requester, with the data cache favoured. A starvation counter bounds instruction-fetch delay. It records the owner of every outstanding load tag so that `mem2proc_tag`/`mem2proc_data` returns reach the right cache, and it drops returns for instruction fetches squashed by a branch flush. It sits between the Icache/Dcache controllers and the core's `proc2mem_*`/`mem2proc_*` pins.

## Interface
- `STARVE_LIMIT`, default 4: consecutive arbitration losses after which the Icache gets priority.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `icache_req_i` in 1: Icache load request.
- `icache_addr_i` in 64: Icache load address.
- `icache_flush_i` in 1: branch flush; squash all outstanding Icache loads.
- `icache_ack_o` out 1: Icache request accepted this cycle.
- `icache_resp_tag_o` out 4: tag assigned to the accepted Icache request; 0 when not accepted.
- `icache_tag_o` out 4: returning tag owned by the Icache; 0 when none.
- `icache_data_o` out 64: returning data, valid when `icache_tag_o`≠0.
- `dcache_req_i` in 1: Dcache request.
- `dcache_cmd_i` in 2: LOAD or STORE.
- `dcache_addr_i` in 64: Dcache address.
- `dcache_data_i` in 64: store data.
- `dcache_ack_o`, `dcache_resp_tag_o`, `dcache_tag_o`, `dcache_data_o`: Dcache equivalents of the Icache outputs.
- `proc2mem_command` out 2, `proc2mem_addr` out 64, `proc2mem_data` out 64: memory request.
- `mem2proc_response` in 4: accepting tag, 0 = rejected.
- `mem2proc_tag` in 4: returning tag.
- `mem2proc_data` in 64: returning data.
- `outstanding_cnt_o` out 5: number of valid table entries.
- `proto_err_o` out 1: sticky; set when a return arrives for an invalid tag.

## Operation
- Commands: NONE=0, LOAD=1, STORE=2. Tags 1–15 are valid; tag 0 means none.
- Arbitration is combinational from the requests and the registered `starve_cnt`:
  - The Icache wins if `starve_cnt`==STARVE_LIMIT, or if `dcache_req_i`=0.
  - Otherwise the Dcache wins.
  - The Icache is never granted in a cycle where `icache_flush_i`=1; the Dcache may be granted in that cycle.
- The granted requester drives `proc2mem_*`. With no grant, `proc2mem_command`=NONE and `proc2mem_addr`/`proc2mem_data`=0.
- Accepted means granted and `mem2proc_response`≠0. The winner's `ack_o`=1 and its `resp_tag_o`=`mem2proc_response`. A rejected or losing requester holds its request and retries; no internal queueing.
- Tag table: 16 entries of {valid, owner(I/D), squashed}.
  - An accepted LOAD allocates entry[response].
  - An accepted STORE allocates nothing.
- Return path: when `mem2proc_tag`≠0 and the entry is valid:
  - Route the tag and data to the owner, unless the entry is squashed; a squashed return is dropped and both `tag_o` stay 0.
  - Clear the entry at the next posedge.
  - If the entry is invalid: drop the return and set `proto_err_o`.
- Flush: at the posedge with `icache_flush_i`=1, every valid owner-I entry gets squashed=1. A return arriving in the flush cycle itself is still delivered.
- `starve_cnt`:
  - Increments, saturating at STARVE_LIMIT, on any cycle where `icache_req_i`=1, `icache_flush_i`=0, and the Dcache was granted.
  - Clears when the Icache is accepted, or when `icache_req_i`=0.
  - Holds otherwise, including memory reject and flush cycles.
- Same-cycle return and allocation of the same tag: the clear applies first and the allocation wins (entry valid, new owner).

## Timing
- Grant, ack, and `resp_tag_o` are combinational in the request cycle. The table and counter update at the following posedge.
- Return routing is combinational from `mem2proc_tag` and the registered table; there is zero added latency.
- Reset (`rst`=0, asynchronous): table cleared, `starve_cnt`=0, `proto_err_o`=0, `outstanding_cnt_o`=0. All outputs 0; `proc2mem_command`=NONE.
- Reset mid-operation drops every outstanding tag. Later returns for those tags set `proto_err_o`.
- `outstanding_cnt_o` is registered. It reflects allocations and clears after the edge, and includes squashed entries.

## Structure
- The shared defines header carries the command encodings (BUS_NONE/LOAD/STORE), tag width 4, and tag count 16.
- One sub-module, `mem_tag_table`: a 16-entry valid/owner/squash array with allocate, clear, flush-squash, lookup, and population count. The arbitration and starvation logic stays in `mem_arbiter`.

## Test plan
- **Dcache priority:** both request, response=3 → Dcache ack, tag 3, command LOAD at the Dcache address; Icache not acked; `starve_cnt`=1.
- **Starvation:** both request continuously with STARVE_LIMIT=4 → Dcache accepted 4 cycles, Icache granted on the 5th; `starve_cnt` then returns to 0.
- **Return routing:** Icache load gets tag 5, Dcache load gets tag 7; memory returns tag 7 then tag 5 → data appears on `dcache_*` then `icache_*`; `outstanding_cnt_o` goes 2→1→0.
- **Flush squash:** Icache loads get tags 2 and 4; pulse `icache_flush_i`; memory returns 2 and 4 → `icache_tag_o` stays 0; entries freed.
- **Store and reject:** Dcache STORE with response=6 → ack, no table entry. Next LOAD with response=0 → no ack; request retried next cycle; `outstanding_cnt_o` unchanged.
- **Protocol error and reset:** return tag 9 with no owner → `proto_err_o`=1, sticky. Assert `rst`=0 mid-traffic → all outputs and the count go to 0 immediately.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared bus command encodings, tag geometry and helpers for the
// Icache/Dcache memory-port arbiter.
package mem_arbiter_pkg;

    localparam int TAG_W   = 4;
    localparam int TAG_NUM = 16;
    localparam int CNT_W   = 5;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    function automatic logic [CNT_W-1:0] popcount(input logic [TAG_NUM-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < TAG_NUM; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/mem_tag_table.sv
// Outstanding-load tag table: per-tag valid/owner/squash state with
// allocate, clear, flush-squash, combinational lookup and a registered count.
module mem_tag_table
    import mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_en,
    input  logic [TAG_W-1:0] alloc_tag,
    input  owner_e           alloc_owner,
    input  logic             clear_en,
    input  logic [TAG_W-1:0] clear_tag,
    input  logic             flush_i,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             lookup_valid,
    output owner_e           lookup_owner,
    output logic             lookup_squash,
    output logic [CNT_W-1:0] count_o
);

    logic             valid_q  [TAG_NUM];
    logic             valid_d  [TAG_NUM];
    logic             squash_q [TAG_NUM];
    logic             squash_d [TAG_NUM];
    owner_e           owner_q  [TAG_NUM];
    owner_e           owner_d  [TAG_NUM];
    logic [TAG_NUM-1:0] valid_d_vec;
    logic [CNT_W-1:0] count_q;

    genvar gi;
    generate
        for (gi = 0; gi < TAG_NUM; gi++) begin : g_entry
            // Order matters: squash, then the return clear, then a new
            // allocation of the same tag overrides both.
            always_comb begin
                valid_d[gi]  = valid_q[gi];
                owner_d[gi]  = owner_q[gi];
                squash_d[gi] = squash_q[gi];
                if (flush_i && valid_q[gi] && owner_q[gi] == OWNER_I) begin
                    squash_d[gi] = 1'b1;
                end
                if (clear_en && clear_tag == TAG_W'(gi)) begin
                    valid_d[gi]  = 1'b0;
                    squash_d[gi] = 1'b0;
                end
                if (alloc_en && alloc_tag == TAG_W'(gi)) begin
                    valid_d[gi]  = 1'b1;
                    owner_d[gi]  = alloc_owner;
                    squash_d[gi] = 1'b0;
                end
            end
            assign valid_d_vec[gi] = valid_d[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAG_NUM; i++) begin
                valid_q[i]  <= 1'b0;
                squash_q[i] <= 1'b0;
                owner_q[i]  <= OWNER_I;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < TAG_NUM; i++) begin
                valid_q[i]  <= valid_d[i];
                squash_q[i] <= squash_d[i];
                owner_q[i]  <= owner_d[i];
            end
            count_q <= popcount(valid_d_vec);
        end
    end

    assign lookup_valid  = valid_q[lookup_tag];
    assign lookup_owner  = owner_q[lookup_tag];
    assign lookup_squash = squash_q[lookup_tag];
    assign count_o       = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single processor-memory port between Icache and Dcache,
// bounds Icache starvation, and routes tagged load returns to their owner.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_req_i,
    input  logic [63:0]       icache_addr_i,
    input  logic              icache_flush_i,
    output logic              icache_ack_o,
    output logic [TAG_W-1:0]  icache_resp_tag_o,
    output logic [TAG_W-1:0]  icache_tag_o,
    output logic [63:0]       icache_data_o,
    input  logic              dcache_req_i,
    input  logic [1:0]        dcache_cmd_i,
    input  logic [63:0]       dcache_addr_i,
    input  logic [63:0]       dcache_data_i,
    output logic              dcache_ack_o,
    output logic [TAG_W-1:0]  dcache_resp_tag_o,
    output logic [TAG_W-1:0]  dcache_tag_o,
    output logic [63:0]       dcache_data_o,
    output logic [1:0]        proc2mem_command,
    output logic [63:0]       proc2mem_addr,
    output logic [63:0]       proc2mem_data,
    input  logic [TAG_W-1:0]  mem2proc_response,
    input  logic [TAG_W-1:0]  mem2proc_tag,
    input  logic [63:0]       mem2proc_data,
    output logic [CNT_W-1:0]  outstanding_cnt_o,
    output logic              proto_err_o
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] LIMIT = SC_W'(STARVE_LIMIT);

    logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
    logic            proto_err_q, proto_err_d;
    logic            grant_i, grant_d, accepted;
    logic            alloc_en, ret_hit, deliver;
    owner_e          alloc_owner, lk_owner;
    logic            lk_valid, lk_squash;

    always_comb begin
        // Grants are qualified by reset so every output reads 0 while held.
        grant_i  = rst && icache_req_i && !icache_flush_i &&
                   (starve_cnt_q == LIMIT || !dcache_req_i);
        grant_d  = rst && dcache_req_i && !grant_i;
        accepted = (grant_i || grant_d) && mem2proc_response != '0;

        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (grant_i) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = icache_addr_i;
        end else if (grant_d) begin
            proc2mem_command = dcache_cmd_i;
            proc2mem_addr    = dcache_addr_i;
            proc2mem_data    = dcache_data_i;
        end

        icache_ack_o      = grant_i && accepted;
        dcache_ack_o      = grant_d && accepted;
        icache_resp_tag_o = icache_ack_o ? mem2proc_response : '0;
        dcache_resp_tag_o = dcache_ack_o ? mem2proc_response : '0;

        alloc_en    = accepted && (grant_i || dcache_cmd_i == BUS_LOAD);
        alloc_owner = grant_i ? OWNER_I : OWNER_D;

        ret_hit       = mem2proc_tag != '0 && lk_valid;
        deliver       = ret_hit && !lk_squash;
        icache_tag_o  = (deliver && lk_owner == OWNER_I) ? mem2proc_tag : '0;
        dcache_tag_o  = (deliver && lk_owner == OWNER_D) ? mem2proc_tag : '0;
        icache_data_o = (icache_tag_o != '0) ? mem2proc_data : '0;
        dcache_data_o = (dcache_tag_o != '0) ? mem2proc_data : '0;

        proto_err_d = proto_err_q || (mem2proc_tag != '0 && !lk_valid);

        starve_cnt_d = starve_cnt_q;
        if (icache_req_i && !icache_flush_i && grant_d) begin
            starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q
                                                   : starve_cnt_q + SC_W'(1);
        end else if (!icache_req_i || icache_ack_o) begin
            starve_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            proto_err_q  <= proto_err_d;
        end
    end

    mem_tag_table u_tag_table (
        .clk           (clk),
        .rst           (rst),
        .alloc_en      (alloc_en),
        .alloc_tag     (mem2proc_response),
        .alloc_owner   (alloc_owner),
        .clear_en      (ret_hit),
        .clear_tag     (mem2proc_tag),
        .flush_i       (icache_flush_i),
        .lookup_tag    (mem2proc_tag),
        .lookup_valid  (lk_valid),
        .lookup_owner  (lk_owner),
        .lookup_squash (lk_squash),
        .count_o       (outstanding_cnt_o)
    );

    assign proto_err_o = proto_err_q;

endmodule
